// File: rtl/fp32_mul_arbiter_if.sv
// Requester-side bundle for fp32_mul_arbiter.
// Requesters present operands on req_* over a valid/ready handshake and
// receive their product on the one-hot rsp_valid strobe with rsp_data.
//   master : requester side (drives req_valid/req_op/req_a/req_b)
//   slave  : arbiter side   (drives req_ready/rsp_valid/rsp_data)
interface fp32_mul_arbiter_if #(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned DATA_A_WIDTH = 32,
  parameter int unsigned DATA_B_WIDTH = 26
);
  logic [N_REQ-1:0]              req_valid;
  logic [N_REQ-1:0]              req_ready;
  logic [N_REQ-1:0]              req_op;
  logic [N_REQ*DATA_A_WIDTH-1:0] req_a;
  logic [N_REQ*DATA_B_WIDTH-1:0] req_b;
  logic [N_REQ-1:0]              rsp_valid;
  logic [DATA_A_WIDTH-1:0]       rsp_data;

  modport master (
    output req_valid, req_op, req_a, req_b,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/fp32_mul_arbiter.sv
// Round-robin arbiter/sequencer sharing one pipelined fp32 multiplier
// between N_REQ requesters. Accepted requests go to an issue register that
// drives the multiplier; {v, id, op} rides a MUL_LATENCY-deep tag pipe so the
// product can be returned to its owner with a one-cycle one-hot strobe.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   req_if (slave)  : request handshake in, response strobe/data out
//   cfg_pause       : stop granting and drain in-flight work
//   mul_data_a_o/b_o: multiplier operands (from issue register)
//   mul_op_o        : op of tag slot OP_STAGE, 0 when that slot is empty
//   mul_data_i      : multiplier result
//   busy            : work in issue stage, tag pipe or response register
// Build option: define FP32_MUL_ARB_PRIO0_EN to give requester 0 strict
// priority (others rotate among themselves); default is pure round-robin.
module fp32_mul_arbiter #(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned DATA_A_WIDTH = 32,
  parameter int unsigned DATA_B_WIDTH = 26,
  parameter int unsigned MUL_LATENCY  = 3,
  parameter int unsigned OP_STAGE     = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  fp32_mul_arbiter_if.slave       req_if,
  input  logic                    cfg_pause,
  output logic [DATA_A_WIDTH-1:0] mul_data_a_o,
  output logic [DATA_B_WIDTH-1:0] mul_data_b_o,
  output logic                    mul_op_o,
  input  logic [DATA_A_WIDTH-1:0] mul_data_i,
  output logic                    busy
);

  localparam int unsigned IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

`ifdef FP32_MUL_ARB_PRIO0_EN
  localparam bit PRIO0_EN = 1'b1;
`else
  localparam bit PRIO0_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_PAUSED = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [IDW-1:0]          rr_ptr_q, rr_ptr_d;
  logic                    iss_v_q, iss_v_d;
  logic [IDW-1:0]          iss_id_q, iss_id_d;
  logic                    iss_op_q, iss_op_d;
  logic [DATA_A_WIDTH-1:0] iss_a_q, iss_a_d;
  logic [DATA_B_WIDTH-1:0] iss_b_q, iss_b_d;

  logic [MUL_LATENCY-1:0]          tag_v_q, tag_v_d;
  logic [MUL_LATENCY-1:0]          tag_op_q, tag_op_d;
  logic [MUL_LATENCY-1:0][IDW-1:0] tag_id_q, tag_id_d;

  logic [N_REQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [DATA_A_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                    mul_op_q, mul_op_d;
  logic                    busy_q, busy_d;

  logic [N_REQ-1:0]        grant_c;
  logic                    gnt_any_c;
  logic [IDW-1:0]          gnt_id_c;
  logic                    gnt_op_c;
  logic [DATA_A_WIDTH-1:0] gnt_a_c;
  logic [DATA_B_WIDTH-1:0] gnt_b_c;

  // Circular search from rr_ptr; pause is sampled combinationally so a
  // pause rising with a request blocks that very grant.
  always_comb begin : grant_sel
    logic           grant_ok;
    logic [IDW-1:0] idx;
    logic [IDW-1:0] cand;
    grant_c   = '0;
    gnt_any_c = 1'b0;
    idx       = '0;
    cand      = '0;
    grant_ok  = rst_n && (state_q == ST_RUN) && !cfg_pause;
    if (grant_ok) begin
      if (PRIO0_EN && req_if.req_valid[0]) begin
        gnt_any_c = 1'b1;
      end
      for (int unsigned k = 0; k < N_REQ; k++) begin
        cand = IDW'((32'(rr_ptr_q) + k) % N_REQ);
        // With priority enabled requester 0 is out of the rotation.
        if (!gnt_any_c && req_if.req_valid[cand] && !(PRIO0_EN && cand == '0)) begin
          gnt_any_c = 1'b1;
          idx       = cand;
        end
      end
    end
    if (gnt_any_c) begin
      grant_c[idx] = 1'b1;
    end
    gnt_id_c = idx;
    gnt_op_c = req_if.req_op[idx];
    gnt_a_c  = req_if.req_a[idx*DATA_A_WIDTH +: DATA_A_WIDTH];
    gnt_b_c  = req_if.req_b[idx*DATA_B_WIDTH +: DATA_B_WIDTH];
  end

  assign req_if.req_ready = grant_c;

  // Next-state for pointer, issue stage, tag pipe and response register.
  always_comb begin : dp_next
    rr_ptr_d = rr_ptr_q;
    iss_v_d  = gnt_any_c;
    iss_id_d = iss_id_q;
    iss_op_d = iss_op_q;
    iss_a_d  = iss_a_q;
    iss_b_d  = iss_b_q;
    if (gnt_any_c) begin
      iss_id_d = gnt_id_c;
      iss_op_d = gnt_op_c;
      iss_a_d  = gnt_a_c;
      iss_b_d  = gnt_b_c;
      // A priority grant to requester 0 leaves the rotation untouched.
      if (!(PRIO0_EN && gnt_id_c == '0)) begin
        rr_ptr_d = IDW'((32'(gnt_id_c) + 32'd1) % N_REQ);
      end
    end

    tag_v_d     = '0;
    tag_op_d    = '0;
    tag_id_d    = '0;
    tag_v_d[0]  = iss_v_q;
    tag_op_d[0] = iss_op_q;
    tag_id_d[0] = iss_id_q;
    for (int unsigned k = 1; k < MUL_LATENCY; k++) begin
      tag_v_d[k]  = tag_v_q[k-1];
      tag_op_d[k] = tag_op_q[k-1];
      tag_id_d[k] = tag_id_q[k-1];
    end

    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (tag_v_q[MUL_LATENCY-1]) begin
      rsp_valid_d[tag_id_q[MUL_LATENCY-1]] = 1'b1;
      rsp_data_d                           = mul_data_i;
    end

    // Registered from the slot's next value, so it lines up with the slot.
    mul_op_d = tag_v_d[OP_STAGE] & tag_op_d[OP_STAGE];
    busy_d   = iss_v_d | (|tag_v_d) | (|rsp_valid_d);
  end

  always_ff @(posedge clk) begin : dp_regs
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      iss_v_q     <= 1'b0;
      iss_id_q    <= '0;
      iss_op_q    <= 1'b0;
      iss_a_q     <= '0;
      iss_b_q     <= '0;
      tag_v_q     <= '0;
      tag_op_q    <= '0;
      tag_id_q    <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      mul_op_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      iss_v_q     <= iss_v_d;
      iss_id_q    <= iss_id_d;
      iss_op_q    <= iss_op_d;
      iss_a_q     <= iss_a_d;
      iss_b_q     <= iss_b_d;
      tag_v_q     <= tag_v_d;
      tag_op_q    <= tag_op_d;
      tag_id_q    <= tag_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      mul_op_q    <= mul_op_d;
      busy_q      <= busy_d;
    end
  end

  // Pause FSM state register.
  always_ff @(posedge clk) begin : fsm_reg
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Pause FSM next state; dropping pause while draining resumes at once.
  always_comb begin : fsm_next
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (cfg_pause) begin
          state_d = busy_q ? ST_DRAIN : ST_PAUSED;
        end
      end
      ST_DRAIN: begin
        if (!cfg_pause) begin
          state_d = ST_RUN;
        end else if (!busy_q) begin
          state_d = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        if (!cfg_pause) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign mul_data_a_o     = iss_a_q;
  assign mul_data_b_o     = iss_b_q;
  assign mul_op_o         = mul_op_q;
  assign busy             = busy_q;
  assign req_if.rsp_valid = rsp_valid_q;
  assign req_if.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_fp32_mul_arbiter.sv
// Testbench for fp32_mul_arbiter: directed scenarios plus a per-cycle
// reference model of grants, responses, busy, op alignment and multiplier
// operands. A small stub stands in for the pipelined multiplier.
module tb_fp32_mul_arbiter;
  localparam int unsigned N       = 4;
  localparam int unsigned AW      = 32;
  localparam int unsigned BW      = 26;
  localparam int unsigned LAT     = 3;
  localparam int unsigned OPS     = 2;
  localparam int unsigned RSP_LAT = LAT + 2;
  localparam int unsigned MAXC    = 1024;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_pause;
  logic [AW-1:0] mul_data_a_o;
  logic [BW-1:0] mul_data_b_o;
  logic          mul_op_o;
  logic [AW-1:0] mul_data_i;
  logic          busy;

  fp32_mul_arbiter_if #(.N_REQ(N), .DATA_A_WIDTH(AW), .DATA_B_WIDTH(BW)) ifc ();

  fp32_mul_arbiter #(
    .N_REQ(N), .DATA_A_WIDTH(AW), .DATA_B_WIDTH(BW),
    .MUL_LATENCY(LAT), .OP_STAGE(OPS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_if       (ifc),
    .cfg_pause    (cfg_pause),
    .mul_data_a_o (mul_data_a_o),
    .mul_data_b_o (mul_data_b_o),
    .mul_op_o     (mul_op_o),
    .mul_data_i   (mul_data_i),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  // Golden product: exponents add (bias 127), 1.23 x 1.17 mantissas.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [25:0] b);
    logic [41:0] p;
    logic [7:0]  e;
    p = 42'(a[23:0]) * 42'(b[17:0]);
    e = a[31:24] + b[25:18] - 8'd127;
    return {e, p[40:17]};
  endfunction

  // Multiplier stub: captures operands each edge, result LAT edges later.
  logic [AW-1:0] mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= fmul(mul_data_a_o, mul_data_b_o);
    for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
  end
  assign mul_data_i = mpipe[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Grant rule: first valid at/after rr, circular; optional strict prio 0.
  function automatic bit [3:0] model_grant(input bit [3:0] v, input int rr, input bit ok,
                                           output int id);
    int j;
    id = -1;
    if (ok) begin
`ifdef FP32_MUL_ARB_PRIO0_EN
      if (v[0]) id = 0;
`endif
      for (int k = 0; k < N; k++) begin
        j = (rr + k) % N;
`ifdef FP32_MUL_ARB_PRIO0_EN
        if (j == 0) continue;
`endif
        if (id < 0 && v[j]) id = j;
      end
    end
    return (id >= 0) ? 4'(1 << id) : 4'b0;
  endfunction

  function automatic int at(input int q[$], input int k);
    return (k < q.size()) ? q[k] : -1;
  endfunction

  // Expected outputs indexed by cycle number.
  bit [3:0]  exp_rv [MAXC];
  bit [31:0] exp_rd [MAXC];
  bit        exp_op [MAXC];
  bit        hs_at  [MAXC];
  bit        ia_v   [MAXC];
  bit [31:0] ia     [MAXC];
  bit [25:0] ib     [MAXC];
  bit        op_seen[MAXC];

  int        rr_m = 0;
  bit        pause_prev = 1'b0;
  bit [31:0] rd_hold = '0;
  bit [31:0] a_hold = '0;
  bit [25:0] b_hold = '0;
  int        gid;
  int        rid;
  bit [3:0]  eg;
  bit        bexp;

  int        gl_id[$];
  int        gl_cyc[$];
  int        rl_id[$];
  int        rl_cyc[$];
  bit [31:0] rl_data[$];

  // Compare process: checks DUT against the model, then advances the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("ready_in_reset", ifc.req_ready, '0);
      for (int k = 0; k <= RSP_LAT + 3; k++) begin
        exp_rv[cyc+k] = '0;
        exp_op[cyc+k] = 1'b0;
        ia_v[cyc+k]   = 1'b0;
      end
      for (int k = 1; k <= RSP_LAT; k++) if (cyc >= k) hs_at[cyc-k] = 1'b0;
      rr_m = 0; pause_prev = 1'b0;
      rd_hold = '0; a_hold = '0; b_hold = '0;
    end else begin
      eg = model_grant(ifc.req_valid, rr_m, !cfg_pause && !pause_prev, gid);
      chk("req_ready", ifc.req_ready, eg);
      chk("rsp_valid", ifc.rsp_valid, exp_rv[cyc]);
      if (exp_rv[cyc] != 0) rd_hold = exp_rd[cyc];
      chk("rsp_data", ifc.rsp_data, rd_hold);
      bexp = 1'b0;
      for (int k = 1; k <= RSP_LAT; k++) if (cyc >= k && hs_at[cyc-k]) bexp = 1'b1;
      chk("busy", busy, bexp);
      chk("mul_op_o", mul_op_o, exp_op[cyc]);
      if (ia_v[cyc]) begin
        a_hold = ia[cyc];
        b_hold = ib[cyc];
      end
      chk("mul_data_a_o", mul_data_a_o, a_hold);
      chk("mul_data_b_o", mul_data_b_o, b_hold);
      op_seen[cyc] = mul_op_o;
      if (ifc.rsp_valid != 0) begin
        rid = -1;
        for (int k = 0; k < N; k++) if (ifc.rsp_valid[k]) rid = k;
        rl_id.push_back(rid);
        rl_cyc.push_back(cyc);
        rl_data.push_back(ifc.rsp_data);
      end
      if (gid >= 0) begin
        hs_at[cyc]            = 1'b1;
        exp_rv[cyc+RSP_LAT]   = 4'(1 << gid);
        exp_rd[cyc+RSP_LAT]   = fmul(ifc.req_a[gid*AW +: AW], ifc.req_b[gid*BW +: BW]);
        exp_op[cyc+2+OPS]     = ifc.req_op[gid];
        ia_v[cyc+1]           = 1'b1;
        ia[cyc+1]             = ifc.req_a[gid*AW +: AW];
        ib[cyc+1]             = ifc.req_b[gid*BW +: BW];
        gl_id.push_back(gid);
        gl_cyc.push_back(cyc);
`ifdef FP32_MUL_ARB_PRIO0_EN
        if (gid != 0) rr_m = (gid + 1) % N;
`else
        rr_m = (gid + 1) % N;
`endif
      end
      pause_prev = cfg_pause;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    gl_id.delete(); gl_cyc.delete();
    rl_id.delete(); rl_cyc.delete(); rl_data.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
  endtask

  initial begin
    int bf;
    int rc;
    int h;
    int ord[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    rst_n = 1'b0; cfg_pause = 1'b0;
    ifc.req_valid = '0; ifc.req_op = '0; ifc.req_a = '0; ifc.req_b = '0;
    for (int i = 0; i < N; i++) begin
      ifc.req_a[i*AW +: AW] = {8'(124 + i), 24'h800000 | 24'(i * 4097)};
      ifc.req_b[i*BW +: BW] = {8'(126 + i), 18'h20000 | 18'(i * 33)};
    end
    ifc.req_a[1*AW +: AW] = 32'h7F80_0000;
    ifc.req_b[1*BW +: BW] = 26'h203_0000;
    chk("golden_pin", fmul(32'h7F80_0000, 26'h203_0000), 32'h80C0_0000);
    step(3);
    rst_n = 1'b1;
    step(2);

    // Single request from requester 1.
    clear_logs();
    ifc.req_valid = 4'b0010;
    step(1);
    ifc.req_valid = '0;
    step(8);
    chk("single_gnt_n", gl_id.size(), 1);
    chk("single_gnt_id", at(gl_id, 0), 1);
    chk("single_rsp_n", rl_id.size(), 1);
    chk("single_rsp_id", at(rl_id, 0), 1);
    chk("single_rsp_lat", at(rl_cyc, 0) - at(gl_cyc, 0), 5);
    chk("single_rsp_data", (rl_data.size() > 0) ? rl_data[0] : 32'h0, 32'h80C0_0000);

`ifndef FP32_MUL_ARB_PRIO0_EN
    // Fairness: all requesters valid for 8 cycles from reset.
    do_reset();
    step(1);
    clear_logs();
    ifc.req_valid = 4'hF;
    step(8);
    ifc.req_valid = '0;
    step(8);
    chk("fair_gnt_n", gl_id.size(), 8);
    chk("fair_rsp_n", rl_id.size(), 8);
    for (int k = 0; k < 8; k++) begin
      chk("fair_gnt_order", at(gl_id, k), ord[k]);
      chk("fair_rsp_order", at(rl_id, k), ord[k]);
      chk("fair_rsp_no_gap", at(rl_cyc, k), at(rl_cyc, 0) + k);
    end
`else
    // Strict priority: requester 0 always wins, 2 gets the next free cycle.
    clear_logs();
    ifc.req_valid = 4'b0101;
    step(5);
    ifc.req_valid = 4'b0100;
    step(1);
    ifc.req_valid = '0;
    step(8);
    chk("prio_gnt_n", gl_id.size(), 6);
    for (int k = 0; k < 5; k++) chk("prio_gnt_0", at(gl_id, k), 0);
    chk("prio_gnt_2", at(gl_id, 5), 2);
    chk("prio_gnt_2_cyc", at(gl_cyc, 5), at(gl_cyc, 4) + 1);
`endif

    // Pause with a full pipeline, then resume from the saved pointer.
    do_reset();
    step(1);
    clear_logs();
    ifc.req_valid = 4'hF;
    step(5);
    cfg_pause = 1'b1;
    bf = -1;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      if (bf < 0 && busy == 1'b0) bf = k;
    end
    chk("pause_busy_fall_in_bound", (bf > 0 && bf <= 5), 1'b1);
    chk("pause_no_grant", gl_id.size(), 5);
    cfg_pause = 1'b0;
    rc = cyc;
    step(3);
    ifc.req_valid = '0;
    step(8);
`ifdef FP32_MUL_ARB_PRIO0_EN
    chk("resume_id", at(gl_id, 5), 0);
`else
    chk("resume_id", at(gl_id, 5), 1);
`endif
    chk("resume_cyc", at(gl_cyc, 5), rc + 1);

    // Reset with three operations in flight.
    clear_logs();
    ifc.req_valid = 4'hF;
    step(3);
    ifc.req_valid = '0;
    do_reset();
    chk("rst_busy_after", busy, 1'b0);
    ifc.req_valid = 4'hF;
    step(1);
    ifc.req_valid = '0;
    step(8);
    chk("rst_gnt_n", gl_id.size(), 4);
    chk("rst_first_gnt", at(gl_id, 3), 0);
    chk("rst_rsp_n", rl_id.size(), 1);
    chk("rst_rsp_id", at(rl_id, 0), 0);

    // Op alignment: ops 1,0,1 on back-to-back grants.
    clear_logs();
    ifc.req_valid = 4'b0001;
    ifc.req_op = 4'b0001;
    step(1);
    ifc.req_op = 4'b0000;
    step(1);
    ifc.req_op = 4'b0001;
    step(1);
    ifc.req_valid = '0;
    ifc.req_op = '0;
    step(10);
    chk("op_gnt_n", gl_id.size(), 3);
    h = at(gl_cyc, 0);
    if (h < 0) h = 0;
    chk("op_pre", op_seen[h+3], 1'b0);
    chk("op_1", op_seen[h+4], 1'b1);
    chk("op_0", op_seen[h+5], 1'b0);
    chk("op_1b", op_seen[h+6], 1'b1);
    chk("op_post", op_seen[h+7], 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fp32_mul_arbiter.md
# fp32_mul_arbiter

Round-robin arbiter and sequencer that shares one pipelined `fp32_multiplier` instance between `N_REQ` requesters. Each request is accepted over a valid/ready handshake and registered into an issue stage. The requester ID and op travel through a tag pipeline matched to the multiplier latency. Each product is returned to its owner with a one-cycle response strobe. The block sits between the PE-side operand sources and the multiplier datapath, and owns all multiplier input sequencing.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `DATA_A_WIDTH`, 32: operand A / result width ({exponent 8, mantissa 24}).
- `DATA_B_WIDTH`, 26: operand B width ({exponent 8, mantissa 18}).
- `MUL_LATENCY`, 3: multiplier cycles from operand capture to valid `mul_data_o`.
- `OP_STAGE`, 2: tag-pipeline slot (0..`MUL_LATENCY`-1) whose op drives `mul_op_o`.

Ports:
- `clk` in 1: clock, all logic on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in `N_REQ`: per-requester request valid.
- `req_ready` out `N_REQ`: per-requester grant; one-hot or zero.
- `req_op` in `N_REQ`: per-requester op bit.
- `req_a` in `N_REQ*DATA_A_WIDTH`: packed A operands; requester i occupies slice i.
- `req_b` in `N_REQ*DATA_B_WIDTH`: packed B operands.
- `cfg_pause` in 1: stop granting and drain in-flight work.
- `mul_data_a_o` out `DATA_A_WIDTH`: to multiplier A input.
- `mul_data_b_o` out `DATA_B_WIDTH`: to multiplier B input.
- `mul_op_o` out 1: to multiplier `mul_op`.
- `mul_data_i` in `DATA_A_WIDTH`: multiplier result.
- `rsp_valid` out `N_REQ`: one-hot response strobe, one cycle.
- `rsp_data` out `DATA_A_WIDTH`: registered result.
- `busy` out 1: high whenever any operation is in the issue stage, the tag pipeline, or the response register.

## Operation
- **Grant.** Combinational: `req_ready[i]` = the first `req_valid` bit at or after `rr_ptr`, circular search. A handshake occurs when `req_valid[i] & req_ready[i]`.
- **Grant blocking.** No grant while in state PAUSED or DRAIN.
- **Round-robin pointer.** On a handshake by i, `rr_ptr` <= (i+1) mod `N_REQ`. With no handshake, `rr_ptr` holds.
- **Issue register.** On a handshake, captures {a, b, op, id=i, v=1}. Without a handshake, v <= 0 and the data fields hold their last value.
- **Multiplier inputs.** `mul_data_a_o` and `mul_data_b_o` are driven from the issue register.
- **Tag pipeline.** `MUL_LATENCY` slots of {v, id, op}, shifted every cycle, with no stall. Slot 0 loads from the issue register. `mul_op_o` = op of slot `OP_STAGE`, or 0 if that slot is invalid.
- **Response.** When the last slot is valid, `rsp_data` <= `mul_data_i` and `rsp_valid` <= onehot(id). Otherwise `rsp_valid` <= 0 and `rsp_data` holds.
- **No backpressure.** Responses cannot be refused; requesters must sink them.
- **State machine:**
  - RUN: default state.
  - RUN -> DRAIN when `cfg_pause`=1 and `busy`=1.
  - RUN -> PAUSED when `cfg_pause`=1 and `busy`=0.
  - DRAIN -> PAUSED when `busy`=0.
  - PAUSED -> RUN when `cfg_pause`=0.
  - DRAIN -> RUN when `cfg_pause`=0, even with work still in flight.
- **Simultaneous events.** A `cfg_pause` rise on the same cycle as a request blocks that grant (pause is sampled combinationally).
- **Reset.** Reset mid-operation discards all in-flight work; no response is produced for it.

## Timing
- **Reset values:**
  - `req_ready`=0 while `rst_n`=0.
  - `mul_data_a_o`=0, `mul_data_b_o`=0, `mul_op_o`=0.
  - `rsp_valid`=0, `rsp_data`=0, `busy`=0.
  - State RUN, `rr_ptr`=0, all valid bits 0.
- **Latency.** Handshake at edge T gives `rsp_valid` high during cycle T+`MUL_LATENCY`+2, i.e. 5 cycles with default parameters.
- **Throughput.** One accept per cycle sustained. Responses come back in issue order.
- **Pause timing.** From `cfg_pause` rising with a full pipeline to reaching PAUSED takes at most `MUL_LATENCY`+2 cycles.

## Configuration
- **`FP32_MUL_ARB_PRIO0_EN` defined:**
  - Requester 0 has strict priority: when `req_valid[0]`=1 and granting is allowed, it is granted regardless of `rr_ptr`.
  - A requester-0 grant does not move `rr_ptr`.
  - Requesters 1..`N_REQ`-1 rotate round-robin among themselves.
- **Undefined:** pure round-robin across all `N_REQ` requesters.

## Test plan
- **Single request.** Reset, then `req_valid`=0b0010 for one cycle with A/B from the golden model -> `req_ready`=0b0010 on that cycle. `rsp_valid`=0b0010 exactly 5 cycles later. `rsp_data` equals `mul_data_i` sampled the cycle before, which equals the golden product.
- **Fairness.** All four requesters hold valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3. Responses arrive in the same order, one per cycle, no gaps.
- **Pause with full pipeline.** Pause asserted while 4 operations are in flight -> no new grants. State goes through DRAIN and reaches PAUSED with `busy`=0 within 5 cycles. Deasserting pause resumes granting from the saved `rr_ptr`.
- **Reset mid-flight.** `rst_n` low for 1 cycle with 3 operations in flight -> no `rsp_valid` on any later cycle. `rr_ptr`=0 and `busy`=0 the cycle after reset releases.
- **Op alignment.** Alternating `req_op` 1,0,1 on back-to-back grants -> `mul_op_o` shows 1,0,1 starting `OP_STAGE`+2 cycles after the first handshake.
- **Priority build.** With `FP32_MUL_ARB_PRIO0_EN` defined, requesters 0 and 2 are continuously valid -> requester 0 wins every cycle. Requester 2 is granted in the first cycle after requester 0 drops.
